mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of request and DMem addresses.
REQ-002 SHALL have input clk, 1 bit, rising-edge clock.
REQ-003 SHALL have input rstn, 1 bit, reset: asynchronous, active-low.
REQ-004 SHALL have input i_req_valid, 1 bit, core load/store request strobe.
REQ-005 SHALL have output o_req_ready, 1 bit, unit idle and able to accept a request.
REQ-006 SHALL have input i_req_we, 1 bit: 1 selects store, 0 selects load.
REQ-007 SHALL have input i_req_size, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have input i_req_unsigned, 1 bit: 1 zero-extends loads, 0 sign-extends them.
REQ-009 SHALL have input i_req_addr, ADDR_W bits, byte address.
REQ-010 SHALL have input i_req_wdata, 32 bits, store data, right-aligned.
REQ-011 SHALL have output o_resp_valid, 1 bit, one-cycle completion pulse.
REQ-012 SHALL have output o_resp_rdata, 32 bits, extended load data.
REQ-013 SHALL have output o_resp_err, 1 bit, misaligned or reserved-size flag, qualified by o_resp_valid.
REQ-014 SHALL have output o_DMem_we, 1 bit, word write enable to data memory.
REQ-015 SHALL have output o_DMem_addr, ADDR_W bits, word-aligned address to data memory.
REQ-016 SHALL have output o_DMem_wData, 32 bits, little-endian write word.
REQ-017 SHALL have input i_DMem_rData, 32 bits, combinational little-endian read word for o_DMem_addr.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP; o_req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on a rising edge with i_req_valid=1 in IDLE, latching all request fields; i_req_valid in other states SHALL be ignored.
REQ-020 SHALL drive o_DMem_addr = latched address with bits[1:0] forced to 00 from the cycle after acceptance until the next acceptance.
REQ-021 SHALL flag a request as erroneous when size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-022 Erroneous request SHALL go IDLE->RESP with no memory access, so o_DMem_we stays 0 and o_resp_err=1, o_resp_rdata=0.
REQ-023 Load SHALL go IDLE->READ->RESP: i_DMem_rData captured at end of READ; o_resp_valid asserted 2 cycles after acceptance.
REQ-024 Load extraction SHALL work as follows: byte = rData[8*addr[1:0]+:8]; half = rData[16*addr[1]+:16]; word = rData; then sign- or zero-extend to 32 per i_req_unsigned.
REQ-025 Word store SHALL go IDLE->WRITE->RESP: o_DMem_we=1 for exactly the WRITE cycle, with o_DMem_wData=wdata.
REQ-026 Byte/half store SHALL go IDLE->READ->WRITE->RESP as a read-modify-write: in WRITE, o_DMem_wData = captured word with the addressed byte/half lane replaced by wdata[7:0]/wdata[15:0]; other lanes SHALL be unchanged.
REQ-027 o_resp_valid SHALL be high only in RESP, for exactly one cycle; RESP SHALL always return to IDLE.
REQ-028 Store responses SHALL have o_resp_rdata=0 and o_resp_err=0.
REQ-029 o_DMem_we SHALL be 0 in every state except WRITE.
REQ-030 o_DMem_wData SHALL hold its last value outside WRITE.
REQ-031 A new request SHALL be accepted at the earliest one cycle after RESP (back-to-back throughput = latency+1).
REQ-032 Address wrap SHALL be left to the memory; the unit SHALL perform no range check beyond alignment.

Reset
REQ-033 rstn=0 SHALL asynchronously force state=IDLE, o_req_ready=1, o_resp_valid=0, o_resp_err=0, o_resp_rdata=0, o_DMem_we=0, o_DMem_addr=0, o_DMem_wData=0, and all latched request fields=0.
REQ-034 Reset asserted in READ or WRITE SHALL abort the access with no write committed after reset assertion and no response issued.
REQ-035 After rstn rises, the first rising edge SHALL be able to accept a request.

Verification
REQ-036 Memory word 0x10 = 0x8899AABB; lb at 0x11 -> resp at cycle +2, rdata=0xFFFFFFAA, err=0; lbu at 0x11 -> 0x000000AA.
REQ-037 Same word; lh at 0x12 -> 0xFFFF8899; lhu at 0x12 -> 0x00008899; lw at 0x10 -> 0x8899AABB.
REQ-038 sb wdata=0x123456CC at 0x13 -> one write of 0xCC99AABB to word 0x10, resp at cycle +3; sh wdata=0x00001234 at 0x10 -> 0xCC991234.
REQ-039 sw 0xDEADBEEF at 0x20 -> o_DMem_we=1 for exactly 1 cycle with addr 0x20, resp at cycle +2; lw at 0x20 then returns 0xDEADBEEF.
REQ-040 lw at 0x22, sh at 0x21, size=11 at 0x0 -> each gives resp at cycle +1, err=1, rdata=0, and o_DMem_we never asserted.
REQ-041 rstn pulsed low during WRITE of sb at 0x13 -> o_DMem_we drops immediately, word 0x10 unchanged, no o_resp_valid, o_req_ready=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit between a core request port and a word-wide
//               data memory, with sub-word read-modify-write stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_DMem_we,
  output logic [ADDR_W-1:0] o_DMem_addr,
  output logic [31:0]       o_DMem_wData,
  input  logic [31:0]       i_DMem_rData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_RSVD = 2'b11;

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_dmem_wdata;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_err;

  logic               w_accept;
  logic               w_err;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load_data;
  logic [31:0]        w_merge_data;

  assign w_accept = (r_state == IDLE) && i_req_valid;

  always_comb begin
    w_err = 1'b0;
    case (i_req_size)
      c_SIZE_RSVD: w_err = 1'b1;
      c_SIZE_HALF: w_err = i_req_addr[0];
      c_SIZE_WORD: w_err = |i_req_addr[1:0];
      default:     w_err = 1'b0;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores both
  // work on the word currently returned by memory for the latched address.
  always_comb begin
    w_byte = i_DMem_rData[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = i_DMem_rData[15:8];
      2'd2:    w_byte = i_DMem_rData[23:16];
      2'd3:    w_byte = i_DMem_rData[31:24];
      default: w_byte = i_DMem_rData[7:0];
    endcase
    w_half = r_addr[1] ? i_DMem_rData[31:16] : i_DMem_rData[15:0];

    case (r_size)
      c_SIZE_BYTE: w_load_data = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      c_SIZE_HALF: w_load_data = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default:     w_load_data = i_DMem_rData;
    endcase

    w_merge_data = i_DMem_rData;
    if (r_size == c_SIZE_BYTE) begin
      case (r_addr[1:0])
        2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
        2'd2:    w_merge_data[23:16] = r_wdata[7:0];
        2'd3:    w_merge_data[31:24] = r_wdata[7:0];
        default: w_merge_data[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merge_data[31:16] = r_wdata[15:0];
    end else begin
      w_merge_data[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we       <= i_req_we;
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_addr     <= i_req_addr;
        r_wdata    <= i_req_wdata;
      end
      case (r_state)
        IDLE: begin
          if (w_accept && w_err) begin
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b1;
          end else if (w_accept && i_req_we && (i_req_size == c_SIZE_WORD)) begin
            r_dmem_wdata <= i_req_wdata;
          end
        end
        READ: begin
          if (r_we) begin
            r_dmem_wdata <= w_merge_data;
          end else begin
            r_resp_rdata <= w_load_data;
            r_resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          r_resp_rdata <= 32'd0;
          r_resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_DMem_we    = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_err)
            w_next = RESP;
          else if (i_req_we && (i_req_size == c_SIZE_WORD))
            w_next = WRITE;
          else
            w_next = READ;
        end
      end
      READ:  w_next = r_we ? WRITE : RESP;
      WRITE: begin
        o_DMem_we = 1'b1;
        w_next    = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_DMem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_DMem_wData = r_dmem_wdata;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

`default_nettype wire
